uart_core: RTL
==============

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115_200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, 8, character width, legal range 5..8.
REQ-004 Parameter PARITY, PAR_NONE, parity mode of type parity_t: PAR_NONE, PAR_ODD or PAR_EVEN.
REQ-005 Parameter STOP_BITS, 1, stop bits transmitted, legal values 1 or 2.
REQ-006 Parameter RX_FIFO_DEPTH, 16, RX FIFO entries, power of 2, minimum 2.
REQ-007 The block SHALL use one clock and an asynchronous active-high reset.
REQ-008 Ports SHALL be as follows.
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- tx_data  in  8  character to send; bits above DATA_BITS-1 ignored
- tx_valid  in  1  TX request
- tx_ready  out  1  TX idle, can accept a character
- rx_data  out  8  FIFO head character, zero-extended
- rx_perr  out  1  parity error flag of the head entry
- rx_ferr  out  1  framing error flag of the head entry
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  pop FIFO head
- rx_overrun  out  1  sticky: a character was dropped because the FIFO was full
- err_clr  in  1  clears rx_overrun
- uart_rx  in  1  serial input, asynchronous
- uart_tx  out  1  serial output

Function
REQ-009 Oversample tick SHALL pulse once every DIV clocks, where DIV = round(CLK_HZ/(16*BAUD)) and is at least 1; one bit time SHALL be exactly 16*DIV clocks.
REQ-010 TX handshake: a character SHALL be accepted on any clk edge where tx_valid and tx_ready are both high; tx_ready SHALL fall on the next cycle and SHALL remain low until the last stop bit has completed.
REQ-011 TX state machine SHALL use the states IDLE, START, DATA, PAR, STOP, with transition IDLE->START on accept.
- START drives the start bit (0), beginning the cycle after accept.
- DATA sends DATA_BITS bits, LSB first.
- PAR is skipped when PARITY is PAR_NONE; for odd/even parity the total count of ones in data plus parity bit is odd/even respectively.
- STOP drives 1 for STOP_BITS bit times, then returns to IDLE.
REQ-012 Back-to-back TX: if tx_valid is held high, the next start bit SHALL begin no more than 2 cycles after the previous stop bit ends.
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-014 RX state machine SHALL use the states IDLE, START, DATA, PAR, STOP, with transition IDLE->START on a synchronized falling edge.
- START: at tick 8, a high line is a false start -> IDLE with no write; a low line -> DATA.
- DATA, PAR and STOP: each bit is sampled at tick 8 of its bit time.
REQ-015 At the STOP-bit sample the receiver SHALL write {data, perr, ferr} into the FIFO, where ferr = stop bit sampled 0 and perr = parity mismatch (always 0 when PARITY is PAR_NONE); it SHALL then return to IDLE immediately. Only one stop bit is checked.
REQ-016 A character with an error SHALL still be written, with its flags set.
REQ-017 FIFO full at write: the character SHALL be dropped and rx_overrun set; it stays set until err_clr. When err_clr and a new overrun occur in the same cycle, rx_overrun SHALL be 1.
REQ-018 FIFO output SHALL be first-word-fall-through: rx_data, rx_perr and rx_ferr are valid whenever rx_valid is high; a pop happens when rx_valid and rx_ready are both high.
REQ-019 A simultaneous push and pop on a full or empty FIFO SHALL both succeed (empty: data appears the next cycle). Pointers wrap modulo RX_FIFO_DEPTH.

Reset
REQ-020 While rst is high, outputs SHALL be: uart_tx=1, tx_ready=0, rx_valid=0, rx_data=0, rx_perr=0, rx_ferr=0, rx_overrun=0.
- FIFO is emptied, both FSMs are forced to IDLE, tick counter is cleared, synchronizer flops are set to 1.
- tx_ready rises on the first clk edge after rst deasserts.
REQ-021 Reset asserted mid-frame SHALL abort the frame; a partial TX character is lost and uart_tx goes to 1 asynchronously.

Structure
REQ-022 Package uart_pkg SHALL hold parity_t, a typedef uart_rx_entry_t (data[7:0], perr, ferr), and the function computing DIV.
REQ-023 The FIFO SHALL be the sub-module uart_rx_fifo, parametrised by depth and entry type; TX, RX and tick logic stay in uart_core.

Verification (CLK_HZ=50e6, BAUD=115200 -> DIV=27, bit=432 clk)
REQ-024 Send tx_data=0x55 with 8N1 -> uart_tx low for 432 clk, then 1,0,1,0,1,0,1,0 at 432 clk each, then high; tx_ready is low for 4320 clk.
REQ-025 Loopback (uart_tx tied to uart_rx) with 7E2, send 0x41 -> rx_data=0x41, perr=0, ferr=0; uart_tx shows parity bit 0 and 2 stop bits.
REQ-026 Model drives 0xA3 with the stop bit forced 0, then 0x3C correctly -> entries {0xA3, ferr=1} then {0x3C, ferr=0}.
REQ-027 Model drives 17 characters 0x00..0x10 with rx_ready=0 (depth 16) -> first 16 read back in order; 0x10 dropped; rx_overrun=1; err_clr clears it.
REQ-028 A 0.3-bit-time low glitch on uart_rx -> no FIFO write, FSM back in IDLE.
REQ-029 rst asserted during the DATA state of TX and RX -> uart_tx=1 immediately, rx_valid=0; a subsequent 0x5A is sent and received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and the baud divider helper for the UART core and its RX FIFO.
package uart_pkg;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } uart_rx_entry_t;

  // Rounded clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; a push on a full FIFO is dropped
// unless a pop happens in the same cycle.
module uart_rx_fifo import uart_pkg::*; #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = uart_rx_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full;
  logic            push_en;
  logic            pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign dropped = push && !push_en;
  assign head    = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      count_d = count_q + 1'b1;
    else if (!push_en && pop_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_core.sv
// UART transmitter and receiver with 16x oversampling, configurable framing
// and a first-word-fall-through receive FIFO.
module uart_core import uart_pkg::*; #(
  parameter int      CLK_HZ        = 50_000_000,
  parameter int      BAUD          = 115_200,
  parameter int      DATA_BITS     = 8,
  parameter parity_t PARITY        = PAR_NONE,
  parameter int      STOP_BITS     = 1,
  parameter int      RX_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  input  logic       err_clr,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int            DIV       = calc_div(CLK_HZ, BAUD);
  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic          ODD       = (PARITY == PAR_ODD);
  localparam logic [2:0]    LAST_DBIT = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_SBIT = 3'(STOP_BITS - 1);

  uart_state_t    tx_state_q, tx_state_d;
  logic [PW-1:0]  tx_pre_q, tx_pre_d;
  logic [3:0]     tx_tick_q, tx_tick_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_par_q, tx_par_d;
  logic           tx_line_q, tx_line_d;
  logic           tx_rdy_q, tx_rdy_d;
  logic           tx_bit_end;

  logic [1:0]     sync_q, sync_d;
  logic           rx_prev_q, rx_prev_d;
  logic           rx_line;
  logic           rx_fall;
  uart_state_t    rx_state_q, rx_state_d;
  logic [PW-1:0]  rx_pre_q, rx_pre_d;
  logic [3:0]     rx_tick_q, rx_tick_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           rx_perr_q, rx_perr_d;
  logic           rx_sample;
  logic           rx_bit_end;
  logic           rx_push;
  uart_rx_entry_t rx_entry;

  logic           ovr_q, ovr_d;
  uart_rx_entry_t fifo_head;
  logic           fifo_empty;
  logic           fifo_dropped;

  // Each FSM runs its own prescaler, restarted at frame start, so every
  // bit lasts exactly 16*DIV clocks from the first edge of the frame.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_pre_d   = tx_pre_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_bit_end = (tx_pre_q == PRE_LAST) && (tx_tick_q == 4'hF);
    if (tx_state_q != IDLE) begin
      tx_pre_d = (tx_pre_q == PRE_LAST) ? '0 : tx_pre_q + 1'b1;
      if (tx_pre_q == PRE_LAST) tx_tick_d = tx_tick_q + 1'b1;
    end
    case (tx_state_q)
      IDLE: if (tx_valid && tx_rdy_q) begin
        tx_state_d = START;
        tx_pre_d   = '0;
        tx_tick_d  = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_data & DATA_MASK;
        tx_par_d   = (^(tx_data & DATA_MASK)) ^ ODD;
      end
      START: if (tx_bit_end) tx_state_d = DATA;
      DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_DBIT) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY == PAR_NONE) ? STOP : PAR;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      PAR: if (tx_bit_end) tx_state_d = STOP;
      STOP: if (tx_bit_end) begin
        if (tx_bit_q == LAST_SBIT) tx_state_d = IDLE;
        else tx_bit_d = tx_bit_q + 1'b1;
      end
      default: tx_state_d = IDLE;
    endcase
    case (tx_state_d)
      START:   tx_line_d = 1'b0;
      DATA:    tx_line_d = tx_shift_d[0];
      PAR:     tx_line_d = tx_par_d;
      default: tx_line_d = 1'b1;
    endcase
    tx_rdy_d = (tx_state_d == IDLE);
  end

  assign sync_d    = {sync_q[0], uart_rx};
  assign rx_line   = sync_q[1];
  assign rx_prev_d = rx_line;
  assign rx_fall   = rx_prev_q && !rx_line;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_pre_d      = rx_pre_q;
    rx_tick_d     = rx_tick_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_perr_d     = rx_perr_q;
    rx_push       = 1'b0;
    rx_entry.data = rx_shift_q;
    rx_entry.perr = rx_perr_q;
    rx_entry.ferr = !rx_line;
    rx_sample     = (rx_pre_q == PRE_LAST) && (rx_tick_q == 4'd7);
    rx_bit_end    = (rx_pre_q == PRE_LAST) && (rx_tick_q == 4'hF);
    if (rx_state_q != IDLE) begin
      rx_pre_d = (rx_pre_q == PRE_LAST) ? '0 : rx_pre_q + 1'b1;
      if (rx_pre_q == PRE_LAST) rx_tick_d = rx_tick_q + 1'b1;
    end
    case (rx_state_q)
      IDLE: if (rx_fall) begin
        rx_state_d = START;
        rx_pre_d   = '0;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
        rx_shift_d = '0;
        rx_perr_d  = 1'b0;
      end
      START: begin
        if (rx_sample && rx_line) rx_state_d = IDLE;
        else if (rx_bit_end)      rx_state_d = DATA;
      end
      DATA: begin
        if (rx_sample) rx_shift_d[rx_bit_q] = rx_line;
        if (rx_bit_end) begin
          if (rx_bit_q == LAST_DBIT) rx_state_d = (PARITY == PAR_NONE) ? STOP : PAR;
          else rx_bit_d = rx_bit_q + 1'b1;
        end
      end
      PAR: begin
        if (rx_sample)  rx_perr_d = rx_line ^ (^rx_shift_q) ^ ODD;
        if (rx_bit_end) rx_state_d = STOP;
      end
      STOP: if (rx_sample) begin
        rx_push    = 1'b1;
        rx_state_d = IDLE;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // A fresh overrun wins over a clear in the same cycle.
  assign ovr_d = fifo_dropped || (ovr_q && !err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_pre_q   <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_rdy_q   <= 1'b0;
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_pre_q   <= '0;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_pre_q   <= tx_pre_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      tx_rdy_q   <= tx_rdy_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_pre_q   <= rx_pre_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      ovr_q      <= ovr_d;
    end
  end

  uart_rx_fifo #(
    .DEPTH   (RX_FIFO_DEPTH),
    .entry_t (uart_rx_entry_t)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_entry),
    .pop       (rx_ready),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .dropped   (fifo_dropped)
  );

  assign uart_tx    = tx_line_q;
  assign tx_ready   = tx_rdy_q;
  assign rx_valid   = !fifo_empty;
  assign rx_data    = rx_valid ? fifo_head.data : 8'h00;
  assign rx_perr    = rx_valid && fifo_head.perr;
  assign rx_ferr    = rx_valid && fifo_head.ferr;
  assign rx_overrun = ovr_q;

endmodule
